rx_iq_fifo: RTL and testbench
=============================

# rx_iq_fifo

Sample buffer between the DDC output (RX1/RX2 I/Q, 32-bit signed) and the STM32 bus interface. Captures one I/Q set per `iq_valid` rising edge into a circular buffer. The bus interface pops sets on demand, at its own byte-serial pace. Overflow is counted instead of silently overwriting unread data; underflow returns zeros and is flagged.

## Interface
- `DEPTH`, 8: entries; power of two, 4..64.
- `DATA_W`, 32: width of each I/Q component.
- `clk_in` in 1: single clock; the DDC and the bus interface both run on it.
- `reset_n` in 1: asynchronous, active-low reset.
- `iq_valid` in 1: sample strobe, synchronous to `clk_in`; may stay high for several cycles.
- `rx1_i`, `rx1_q`, `rx2_i`, `rx2_q` in DATA_W each: signed DDC outputs, sampled on the cycle the `iq_valid` rising edge is detected.
- `flush` in 1: synchronous clear of pointers and level.
- `rd_req` in 1: pop request, one set per high cycle.
- `rd_valid` out 1: one-cycle pulse; the `rd_*` data is a real sample.
- `rd_rx1_i`, `rd_rx1_q`, `rd_rx2_i`, `rd_rx2_q` out DATA_W each: registered pop data.
- `empty`, `full` out 1: registered status.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow_cnt` out 16: saturating count of dropped samples.

## Operation
- Edge detect: `push = iq_valid & ~iq_valid_d`. `iq_valid_d` resets to 0.
- Push, not full: write all four components at `wr_ptr`, then `wr_ptr+1` modulo DEPTH.
- Push while full, with no pop that cycle: sample dropped; `overflow_cnt` increments, saturating at 16'hFFFF; pointers unchanged.
- Pop, not empty: `rd_*` <= entry at `rd_ptr`; `rd_valid`=1; `rd_ptr+1` modulo DEPTH.
- Pop while empty: `rd_*` <= 0; `rd_valid`=0. The bus interface streams the zeros.
- Push and pop in the same cycle:
  - Not empty: both happen; level unchanged. When full, no drop.
  - Empty: no bypass; pop returns zeros; level becomes 1.
- `level` = number of pushes minus pops. `full` = (level==DEPTH); `empty` = (level==0).
- `flush`: pointers, level and `rd_valid` go to 0; `overflow_cnt` is kept.
  - Any push or pop in the flush cycle is ignored.
  - `iq_valid_d` still updates in the flush cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from `level`, not from pointer comparison.
- Reset values:
  - `rd_*` = 0, `rd_valid` = 0, `empty` = 1, `full` = 0, `level` = 0, `overflow_cnt` = 0.
  - Storage contents are undefined; they are never read before being written.

## Timing
- Pop latency is 1 cycle: `rd_req` high in cycle N gives data and `rd_valid` on the registered outputs in N+1. `rd_*` hold until the next pop.
- Push-to-pop latency: a set pushed in cycle N is readable by an `rd_req` in N+1 (output in N+2).
- Status outputs reflect all events of cycle N from N+1.
- Back-to-back `rd_req` is supported, one set per cycle.
- Reset asserted mid-stream: all state clears immediately (asynchronous). The first push after deassertion needs a fresh `iq_valid` rising edge.

## Configuration
- `RX_IQ_FIFO_RX2_EN` defined:
  - RX2 storage is built.
  - `rd_rx2_i`/`rd_rx2_q` carry data under the same rules as RX1.
- Undefined:
  - RX2 storage is omitted.
  - `rd_rx2_i`/`rd_rx2_q` are constant 0.
  - `rx2_i`/`rx2_q` stay on the port list but are unused.
  - All other behaviour is identical.

## Structure
- Shared package `rx_iq_pkg`:
  - `iq_pair_t` (packed struct: signed `i`, `q`, DATA_W each).
  - `RX_IQ_DEPTH_DEFAULT`.
  - `OVF_CNT_W = 16`.
- Sub-module `rx_iq_fifo_mem`:
  - Simple dual-port memory: one write port, one asynchronous read port, width 2 or 4 × DATA_W selected by the macro.
  - Pointer, level and counter logic stay in the top.

## Test plan
- Empty pops:
  - After reset, 3 `rd_req` pulses -> `rd_valid`=0 and all `rd_*`=0 each time.
  - `empty`=1, `level`=0.
- In-order data:
  - Push 5 sets (rx1_i = 0x100+n, rx1_q = -n, rx2 = ~rx1), then 5 pops -> values back in order, `rd_valid` pulses one cycle after each `rd_req`.
  - `level` goes 5 -> 0.
- Overflow:
  - Push 10 sets with DEPTH=8 and no pops -> `full`=1, `overflow_cnt`=2.
  - 8 pops return sets 0..7; sets 8 and 9 are absent.
- Edge detect and concurrency:
  - `iq_valid` held high 4 cycles -> exactly one push.
  - Push and pop in the same cycle while full -> `level` stays 8, `overflow_cnt` unchanged.
- Wrap-around:
  - 20 push/pop pairs interleaved at level 1 -> every pop equals the matching push; no gaps across pointer wrap.
- Flush and reset:
  - `flush` at level 6 -> `level`=0, `empty`=1, `overflow_cnt` retained.
  - Async `reset_n` pulse mid-pop -> all outputs at reset values within the same cycle.
  - With the macro undefined, `rd_rx2_*` stay 0 throughout.

Source files
------------

// File: rtl/rx_iq_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rx_iq_pkg
// Shared types and constants for the RX I/Q sample FIFO.
//   RX_IQ_DEPTH_DEFAULT  : default number of FIFO entries
//   RX_IQ_DATA_W_DEFAULT : default width of one I or Q component
//   OVF_CNT_W            : width of the saturating overflow counter
//   iq_pair_t            : one signed I/Q pair at the default component width
//   sat_inc()            : increment that sticks at all-ones
// -----------------------------------------------------------------------------
package rx_iq_pkg;

  localparam int RX_IQ_DEPTH_DEFAULT  = 8;
  localparam int RX_IQ_DATA_W_DEFAULT = 32;
  localparam int OVF_CNT_W            = 16;

  typedef struct packed {
    logic signed [RX_IQ_DATA_W_DEFAULT-1:0] i;
    logic signed [RX_IQ_DATA_W_DEFAULT-1:0] q;
  } iq_pair_t;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_iq_fifo_mem.sv
// -----------------------------------------------------------------------------
// rx_iq_fifo_mem
// Simple dual-port sample storage: one synchronous write port, one
// asynchronous read port. No reset: an entry is always written before the
// top level is allowed to read it.
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data (all I/Q lanes of one set, packed)
//   raddr_i   : read address
//   rdata_o   : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module rx_iq_fifo_mem #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_iq_fifo.sv
// -----------------------------------------------------------------------------
// rx_iq_fifo
// Circular sample buffer between the DDC and the bus interface. One I/Q set is
// captured per rising edge of iq_valid; the bus interface pops one set per
// rd_req cycle. A push into a full buffer (with no pop that cycle) is dropped
// and counted; a pop from an empty buffer returns zeros with rd_valid low.
//
// Build option: define RX_IQ_FIFO_RX2_EN to store and return the RX2 pair.
// Without it, RX2 storage is not built, rd_rx2_* are constant zero and the
// rx2_* inputs are ignored.
//
// Ports:
//   clk_in, reset_n           : clock, asynchronous active-low reset
//   iq_valid                  : sample strobe (edge detected internally)
//   rx1_i/q, rx2_i/q          : signed DDC outputs
//   flush                     : synchronous clear of pointers and level
//   rd_req                    : pop request, one set per high cycle
//   rd_valid                  : one-cycle pulse, rd_* holds a real sample
//   rd_rx1_i/q, rd_rx2_i/q    : registered pop data, held until next pop
//   empty, full, level        : registered occupancy status
//   overflow_cnt              : saturating count of dropped samples
// -----------------------------------------------------------------------------
module rx_iq_fifo
  import rx_iq_pkg::*;
#(
  parameter  int DEPTH  = RX_IQ_DEPTH_DEFAULT,
  parameter  int DATA_W = RX_IQ_DATA_W_DEFAULT,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     iq_valid,
  input  logic signed [DATA_W-1:0] rx1_i,
  input  logic signed [DATA_W-1:0] rx1_q,
  input  logic signed [DATA_W-1:0] rx2_i,
  input  logic signed [DATA_W-1:0] rx2_q,
  input  logic                     flush,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic signed [DATA_W-1:0] rd_rx1_i,
  output logic signed [DATA_W-1:0] rd_rx1_q,
  output logic signed [DATA_W-1:0] rd_rx2_i,
  output logic signed [DATA_W-1:0] rd_rx2_q,
  output logic                     empty,
  output logic                     full,
  output logic [LVL_W-1:0]         level,
  output logic [OVF_CNT_W-1:0]     overflow_cnt
);

`ifdef RX_IQ_FIFO_RX2_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 2;
`endif
  localparam int MEM_W = LANES * DATA_W;

  // State
  logic                 iq_valid_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [MEM_W-1:0]     rd_data_q, rd_data_d;

  // Datapath / control
  logic [DATA_W-1:0]    lane_wr [LANES];
  logic [MEM_W-1:0]     wdata;
  logic [MEM_W-1:0]     rdata;
  logic                 push;
  logic                 at_full;
  logic                 do_pop;
  logic                 do_push;
  logic                 drop;

  // Lane order in storage: 0 = rx1_i, 1 = rx1_q, 2 = rx2_i, 3 = rx2_q.
  assign lane_wr[0] = rx1_i;
  assign lane_wr[1] = rx1_q;
`ifdef RX_IQ_FIFO_RX2_EN
  assign lane_wr[2] = rx2_i;
  assign lane_wr[3] = rx2_q;
`else
  logic unused_rx2;
  assign unused_rx2 = ^{rx2_i, rx2_q};
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
    assign wdata[gi*DATA_W +: DATA_W] = lane_wr[gi];
  end

  rx_iq_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W)
  ) u_mem (
    .clk_i   (clk_in),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    push    = iq_valid & ~iq_valid_q;
    at_full = (level_q == LVL_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full buffer with a
    // concurrent pop still accepts the push. An empty buffer never bypasses.
    do_pop  = ~flush & rd_req & (level_q != '0);
    do_push = ~flush & push & (~at_full | do_pop);
    drop    = ~flush & push & at_full & ~do_pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (rd_req) begin
        // Underflowing pops still update the data so the bus streams zeros.
        rd_valid_d = do_pop;
        rd_data_d  = do_pop ? rdata : '0;
      end
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      if (drop) begin
        ovf_d = sat_inc(ovf_q);
      end
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_W'(DEPTH));
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      iq_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      iq_valid_q <= iq_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  assign rd_rx1_i     = rd_data_q[0*DATA_W +: DATA_W];
  assign rd_rx1_q     = rd_data_q[1*DATA_W +: DATA_W];
`ifdef RX_IQ_FIFO_RX2_EN
  assign rd_rx2_i     = rd_data_q[2*DATA_W +: DATA_W];
  assign rd_rx2_q     = rd_data_q[3*DATA_W +: DATA_W];
`else
  assign rd_rx2_i     = '0;
  assign rd_rx2_q     = '0;
`endif

endmodule

// File: tb/tb_rx_iq_fifo.sv
`timescale 1ns/1ps
module tb_rx_iq_fifo;
  import rx_iq_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic clk_in   = 1'b0;
  logic reset_n  = 1'b0;
  logic iq_valid = 1'b0;
  logic flush    = 1'b0;
  logic rd_req   = 1'b0;
  logic signed [DATA_W-1:0] rx1_i = '0, rx1_q = '0, rx2_i = '0, rx2_q = '0;

  logic                     rd_valid;
  logic signed [DATA_W-1:0] rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q;
  logic                     empty, full;
  logic [LVL_W-1:0]         level;
  logic [OVF_CNT_W-1:0]     overflow_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  rx_iq_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .iq_valid     (iq_valid),
    .rx1_i        (rx1_i),
    .rx1_q        (rx1_q),
    .rx2_i        (rx2_i),
    .rx2_q        (rx2_q),
    .flush        (flush),
    .rd_req       (rd_req),
    .rd_valid     (rd_valid),
    .rd_rx1_i     (rd_rx1_i),
    .rd_rx1_q     (rd_rx1_q),
    .rd_rx2_i     (rd_rx2_i),
    .rd_rx2_q     (rd_rx2_q),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .overflow_cnt (overflow_cnt)
  );

  // ---------------- behavioural reference: a queue of sets ----------------
  typedef struct packed {
    iq_pair_t rx1;
    iq_pair_t rx2;
  } iq_set_t;

  iq_set_t m_q[$];
  iq_set_t m_cur;
  iq_set_t m_data   = '0;
  logic    m_prev   = 1'b0;
  logic    m_valid  = 1'b0;
  logic    m_push   = 1'b0;
  int      m_ovf    = 0;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_prev  = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 0;
    end else begin
      m_push    = iq_valid && !m_prev;
      m_prev    = iq_valid;
      m_cur.rx1 = '{i: rx1_i, q: rx1_q};
      m_cur.rx2 = '{i: rx2_i, q: rx2_q};
      m_valid   = 1'b0;
      if (flush) begin
        m_q.delete();
      end else begin
        // Pop sees the occupancy before this cycle's push.
        if (rd_req) begin
          if (m_q.size() > 0) begin
            m_data  = m_q.pop_front();
            m_valid = 1'b1;
          end else begin
            m_data = '0;
          end
        end
        if (m_push) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_cur);
          else if (m_ovf < 65535) m_ovf++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [DATA_W-1:0] exp_rx2(input logic signed [DATA_W-1:0] v);
`ifdef RX_IQ_FIFO_RX2_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Compare DUT against the model on every falling edge while out of reset.
  always @(negedge clk_in) begin
    if (reset_n) begin
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      check("rd_rx1_i", 64'(rd_rx1_i), 64'(m_data.rx1.i));
      check("rd_rx1_q", 64'(rd_rx1_q), 64'(m_data.rx1.q));
      check("rd_rx2_i", 64'(rd_rx2_i), 64'(exp_rx2(m_data.rx2.i)));
      check("rd_rx2_q", 64'(rd_rx2_q), 64'(exp_rx2(m_data.rx2.q)));
      check("level",    64'(level),    64'(m_q.size()));
      check("empty",    64'(empty),    64'(m_q.size() == 0));
      check("full",     64'(full),     64'(m_q.size() == DEPTH));
      check("ovf_cnt",  64'(overflow_cnt), 64'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_data(input int n);
    rx1_i = DATA_W'(32'h100 + n);
    rx1_q = DATA_W'(-n);
    rx2_i = ~rx1_i;
    rx2_q = ~rx1_q;
  endtask

  task automatic push_set(input int n);
    set_data(n);
    iq_valid = 1'b1;
    step();
    iq_valid = 1'b0;
    step();
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    #22 reset_n = 1'b1;
    step();
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow_cnt), 64'd0);

    // Empty pops return zeros with no valid.
    for (int k = 0; k < 3; k++) begin
      pop_one();
      check("empty_pop_valid", 64'(rd_valid), 64'd0);
      check("empty_pop_rx1_i", 64'(rd_rx1_i), 64'd0);
      step();
    end

    // In-order data.
    for (int n = 0; n < 5; n++) push_set(n);
    check("level_after5", 64'(level), 64'd5);
    for (int n = 0; n < 5; n++) begin
      pop_one();
      check("inorder_valid", 64'(rd_valid), 64'd1);
      check("inorder_rx1_i", 64'(rd_rx1_i), 64'(32'h100 + n));
      check("inorder_rx1_q", 64'(rd_rx1_q), 64'(DATA_W'(-n)));
      check("inorder_rx2_i", 64'(rd_rx2_i), 64'(exp_rx2(~DATA_W'(32'h100 + n))));
      step();
      check("valid_pulse", 64'(rd_valid), 64'd0);
    end
    check("level_drained", 64'(level), 64'd0);

    // Overflow: 10 pushes into 8 entries.
    for (int n = 0; n < 10; n++) push_set(n);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_level", 64'(level), 64'd8);
    check("ovf_cnt2", 64'(overflow_cnt), 64'd2);
    for (int n = 0; n < 8; n++) begin
      pop_one();
      check("ovf_pop_rx1_i", 64'(rd_rx1_i), 64'(32'h100 + n));
    end
    step();
    check("ovf_drained_empty", 64'(empty), 64'd1);

    // Concurrent push and pop while full: no drop.
    for (int n = 20; n < 28; n++) push_set(n);
    set_data(30);
    iq_valid = 1'b1;
    rd_req   = 1'b1;
    step();
    iq_valid = 1'b0;
    rd_req   = 1'b0;
    step();
    check("conc_level", 64'(level), 64'd8);
    check("conc_ovf", 64'(overflow_cnt), 64'd2);
    check("conc_rx1_i", 64'(rd_rx1_i), 64'(32'h100 + 20));

    // Flush at level 6 keeps the overflow count.
    pop_one();
    pop_one();
    check("pre_flush_level", 64'(level), 64'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_ovf", 64'(overflow_cnt), 64'd2);

    // iq_valid held high for 4 cycles is a single push.
    set_data(40);
    iq_valid = 1'b1;
    repeat (4) step();
    iq_valid = 1'b0;
    step();
    check("held_valid_level", 64'(level), 64'd1);

    // Interleaved push/pop at level 1 across pointer wrap.
    for (int n = 50; n < 70; n++) begin
      set_data(n);
      iq_valid = 1'b1;
      rd_req   = 1'b1;
      step();
      iq_valid = 1'b0;
      rd_req   = 1'b0;
      check("wrap_rx1_i", 64'(rd_rx1_i), 64'(32'h100 + ((n == 50) ? 40 : n - 1)));
      step();
    end
    check("wrap_level", 64'(level), 64'd1);
    pop_one();

    // Randomized traffic: a filling phase then a draining phase.
    for (int c = 0; c < 1600; c++) begin
      iq_valid = 1'($urandom_range(0, 1));
      rd_req   = ($urandom_range(0, 99) < ((c < 800) ? 20 : 60));
      flush    = ($urandom_range(0, 299) == 0);
      rx1_i = $urandom; rx1_q = $urandom; rx2_i = $urandom; rx2_q = $urandom;
      step();
    end
    iq_valid = 1'b0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    step();

    // Asynchronous reset in the middle of a pop.
    push_set(80);
    push_set(81);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("pre_reset_valid", 64'(rd_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_valid", 64'(rd_valid), 64'd0);
    check("areset_rx1_i", 64'(rd_rx1_i), 64'd0);
    check("areset_level", 64'(level), 64'd0);
    check("areset_empty", 64'(empty), 64'd1);
    check("areset_ovf", 64'(overflow_cnt), 64'd0);
    #10 reset_n = 1'b1;
    step();
    push_set(90);
    pop_one();
    check("post_reset_rx1_i", 64'(rd_rx1_i), 64'(32'h100 + 90));
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
